// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding and
// oversampling points within a bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  // Ticks per bit period and the tick-counter values at which the line is sampled.
  localparam int          OVERSAMPLE   = 8;
  localparam int          CNT_W        = $clog2(OVERSAMPLE);
  localparam logic [2:0]  START_SAMPLE = 3'd3;
  localparam logic [2:0]  BIT_SAMPLE   = 3'd7;

endpackage

// File: rtl/uart_rx_if.sv
// Output handshake of the UART receiver: held word, error flags and the
// consumer's ready. The receiver is the master, the consumer the slave.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    input  overrun_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// selectable reset value so an idle-high line stays high through reset.
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8x-oversampled start/data/(parity)/stop deserialiser with a
// one-entry output register and valid/ready handshake.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN; without it
// the frame is start + DATA_BITS + stop and parity_err is tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic      sys_clk,
  input  logic      reset,
  input  logic      bclk_x8,
  input  logic      rx,
  output logic      busy,
  uart_rx_if.master rx_if
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_q;
  logic                 b8_q;
  logic                 tick;

  uart_rx_state_t       state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q;
`endif

  logic                 load_d;
  logic                 ferr_d;
  logic                 perr_d;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 perr_q;
  logic                 oerr_q;

  rx_sync #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk_i(sys_clk),
    .rst_i(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  // Delayed copies for start-edge detection and baud-tick edge detection.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rx_q <= 1'b1;
      b8_q <= 1'b0;
    end else begin
      rx_q <= rx_s;
      b8_q <= bclk_x8;
    end
  end

  assign tick = bclk_x8 & ~b8_q;

  // The output register loads on the same edge the stop bit is sampled.
  assign load_d = (state_q == STOP) && tick && (cnt_q == BIT_SAMPLE);
  assign ferr_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
  assign perr_d = par_bad_q;
`else
  assign perr_d = 1'b0;
`endif

  // Frame FSM: start qualification, LSB-first shift, optional parity, stop.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // Only a high-to-low transition starts a frame; a stuck-low line does not.
          if (rx_q && !rx_s) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            if (cnt_q == START_SAMPLE) begin
              if (rx_s) begin
                state_q <= IDLE;
              end else begin
                cnt_q     <= '0;
                bit_idx_q <= '0;
                state_q   <= DATA;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == BIT_SAMPLE) begin
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == BIT_SAMPLE) begin
              // Even parity: data bits plus parity bit must XOR to zero.
              par_bad_q <= (^shift_q) ^ rx_s;
              state_q   <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == BIT_SAMPLE) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // One-entry holding register; a load wins over a simultaneous handshake.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else if (load_d) begin
      data_q  <= shift_q;
      valid_q <= 1'b1;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      oerr_q  <= valid_q && !rx_if.rx_ready;
    end else if (valid_q && rx_if.rx_ready) begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end
  end

  assign busy              = (state_q != IDLE);
  assign rx_if.rx_data     = data_q;
  assign rx_if.rx_valid    = valid_q;
  assign rx_if.frame_err   = ferr_q;
  assign rx_if.parity_err  = perr_q;
  assign rx_if.overrun_err = oerr_q;

endmodule
